conv_tap_sched: RTL

Sequencer for one convolution layer. Walks the output feature map in raster order and, for each output pixel, launches all kernel-tap lanes together. It collects each lane's completion into a sticky done vector, and when every lane has finished it presents the pixel coordinate to the accumulator/writeback stage over a valid/ready handshake. It sits between the layer-level control (start/done) and the array of tap lanes that feed the accumulator.

---
 rtl/conv_tap_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/conv_tap_sched.sv
// Raster-order tap-lane sequencer for one convolution layer: issue all lanes, gather completions, hand the pixel to writeback.
// Optional lane timeout: define CONV_TAP_SCHED_TIMEOUT_EN.
module conv_tap_sched #(
    parameter int LANES   = 9,
    parameter int OUT_W   = 4,
    parameter int OUT_H   = 4,
    parameter int CW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LANES-1:0] lane_start,
    input  logic [LANES-1:0] lane_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_row,
    output logic [CW-1:0]    out_col
);

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | lane_start pulse, sticky cleared
    // WAIT   | collecting lane_done into sticky vector
    // EMIT   | presenting pixel, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(OUT_H - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [LANES-1:0]   sticky_q, sticky_d;
    logic               done_q, done_d;
    logic               hs;

`ifdef CONV_TAP_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_hit;
`endif

    assign hs = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        sticky_d   = sticky_q;
        done_d     = 1'b0;
        lane_start = '0;
        out_valid  = 1'b0;
`ifdef CONV_TAP_SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_hit    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lane_start = '1;
                sticky_d   = '0;
                state_d    = S_WAIT;
`ifdef CONV_TAP_SCHED_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            S_WAIT: begin
                sticky_d = sticky_q | lane_done;
                if (&sticky_d) begin
                    state_d = S_EMIT;
                end
`ifdef CONV_TAP_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_LIM) begin
                    // abandon the layer; writeback never sees this pixel
                    err_hit = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (hs) begin
                    if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + CW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            sticky_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

`ifdef CONV_TAP_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign err = err_hit;
`else
    assign err = 1'b0;
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign out_row = row_q;
    assign out_col = col_q;

endmodule
